// File: rtl/exec_issue_ctrl_pkg.sv
// rtl/exec_issue_ctrl_pkg.sv - opcode, state encoding and source-use decode for exec_issue_ctrl
package exec_issue_ctrl_pkg;

    localparam int NUM_REGS = 32;
    localparam int CNT_W    = 3;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HELD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    typedef struct packed {
        logic rs1_used;
        logic rs2_used;
        logic rd_we;
    } src_use_t;

    // rd_we here ignores rd==x0; the caller masks that.
    function automatic src_use_t decode_use(input logic [6:0] opcode);
        src_use_t u;
        u = '0;
        case (opcode)
            OPC_OP, OPC_OP_32:              u = '{rs1_used: 1'b1, rs2_used: 1'b1, rd_we: 1'b1};
            OPC_BRANCH, OPC_STORE:          u = '{rs1_used: 1'b1, rs2_used: 1'b1, rd_we: 1'b0};
            OPC_OP_IMM, OPC_OP_IMM_32,
            OPC_LOAD, OPC_JALR:             u = '{rs1_used: 1'b1, rs2_used: 1'b0, rd_we: 1'b1};
            OPC_LUI, OPC_AUIPC, OPC_JAL:    u = '{rs1_used: 1'b0, rs2_used: 1'b0, rd_we: 1'b1};
            default:                        u = '0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/exec_scoreboard.sv
// rtl/exec_scoreboard.sv - register pending bits, in-flight counter and hazard query
module exec_scoreboard
    import exec_issue_ctrl_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue,
    input  logic                rd_we,
    input  logic [4:0]          rd,
    input  logic [4:0]          rs1,
    input  logic [4:0]          rs2,
    input  logic                rs1_used,
    input  logic                rs2_used,
    input  logic                wb_valid,
    input  logic [4:0]          wb_rd,
    output logic [NUM_REGS-1:0] sb,
    output logic [CNT_W-1:0]    inflight,
    output logic                hazard,
    output logic                full
);

    logic                wb_hit;
    logic [NUM_REGS-1:0] wake;
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] set_mask;
    logic [CNT_W-1:0]    inflight_eff;

    // A writeback only counts when it retires something actually pending.
    assign wb_hit       = wb_valid && (wb_rd != 5'd0) && sb[wb_rd] && (inflight != '0);
    assign wake         = wb_hit ? (NUM_REGS'(1) << wb_rd) : '0;
    assign pending      = sb & ~wake;
    assign set_mask     = (issue && rd_we) ? (NUM_REGS'(1) << rd) : '0;
    assign inflight_eff = inflight - CNT_W'(wb_hit);

    assign hazard = (rs1_used && pending[rs1]) || (rs2_used && pending[rs2]) || (rd_we && pending[rd]);
    assign full   = inflight_eff >= CNT_W'(MAX_INFLIGHT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb       <= '0;
            inflight <= '0;
        end else begin
            sb <= (pending | set_mask) & ~NUM_REGS'(1);
            case ({issue, wb_hit})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: rtl/exec_issue_ctrl.sv
// rtl/exec_issue_ctrl.sv - single-entry issue stage with scoreboard hazards and branch flush
module exec_issue_ctrl
    import exec_issue_ctrl_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int MAX_INFLIGHT = 4,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            dec_valid_i,
    input  logic [XLEN-1:0] dec_pc_i,
    input  logic [31:0]     dec_inst_i,
    output logic            dec_ready_o,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [31:0]     ex_inst_o,
    input  logic            ex_ready_i,
    input  logic            wb_valid_i,
    input  logic [4:0]      wb_rd_i,
    input  logic            br_valid_i,
    output logic [31:0]     sb_o,
    output logic [2:0]      inflight_o,
    output logic [31:0]     stall_cnt_o
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    logic [1:0]      state;
    logic [2:0]      flush_cnt;
    logic [XLEN-1:0] entry_pc;
    logic [31:0]     entry_inst;
    logic [31:0]     stall_cnt;
    src_use_t        use_q;
    logic [4:0]      rd;
    logic            rd_we;
    logic            hazard;
    logic            full;
    logic            held;
    logic            issue;
    logic            accept;

    assign use_q = decode_use(entry_inst[6:0]);
    assign rd    = entry_inst[11:7];
    assign rd_we = use_q.rd_we && (rd != 5'd0);
    assign held  = (state == ST_HELD);

    assign ex_valid_o  = held && !hazard && !full && !br_valid_i;
    assign issue       = ex_valid_o && ex_ready_i;
    assign dec_ready_o = ((state == ST_EMPTY) || issue) && !br_valid_i;
    assign accept      = dec_valid_i && dec_ready_o;

    assign ex_pc_o     = entry_pc;
    assign ex_inst_o   = entry_inst;
    assign stall_cnt_o = stall_cnt;

    exec_scoreboard #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_sb (
        .clk      (clk),
        .reset    (reset),
        .issue    (issue),
        .rd_we    (rd_we),
        .rd       (rd),
        .rs1      (entry_inst[19:15]),
        .rs2      (entry_inst[24:20]),
        .rs1_used (use_q.rs1_used),
        .rs2_used (use_q.rs2_used),
        .wb_valid (wb_valid_i),
        .wb_rd    (wb_rd_i),
        .sb       (sb_o),
        .inflight (inflight_o),
        .hazard   (hazard),
        .full     (full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_EMPTY;
            flush_cnt <= '0;
        end else if (br_valid_i) begin
            // Redirect drops the held entry; older issued insts still retire through the scoreboard.
            flush_cnt <= FLUSH_LOAD;
            state     <= (FLUSH_CYCLES > 0) ? ST_FLUSH : ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept) state <= ST_HELD;
                ST_HELD:  if (issue)  state <= accept ? ST_HELD : ST_EMPTY;
                ST_FLUSH: begin
                    if (flush_cnt <= 3'd1) begin
                        flush_cnt <= '0;
                        state     <= ST_EMPTY;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                default:  state <= ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry_pc   <= '0;
            entry_inst <= '0;
        end else if (accept) begin
            entry_pc   <= dec_pc_i;
            entry_inst <= dec_inst_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (held && !issue && !br_valid_i && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// tb/tb_exec_issue_ctrl.sv - scoreboard bench for exec_issue_ctrl
module tb_exec_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        dec_valid_i;
    logic [63:0] dec_pc_i;
    logic [31:0] dec_inst_i;
    logic        dec_ready_o;
    logic        ex_valid_o;
    logic [63:0] ex_pc_o;
    logic [31:0] ex_inst_o;
    logic        ex_ready_i;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_i;
    logic        br_valid_i;
    logic [31:0] sb_o;
    logic [2:0]  inflight_o;
    logic [31:0] stall_cnt_o;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    exec_issue_ctrl #(.XLEN(64), .MAX_INFLIGHT(4), .FLUSH_CYCLES(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .dec_valid_i (dec_valid_i),
        .dec_pc_i    (dec_pc_i),
        .dec_inst_i  (dec_inst_i),
        .dec_ready_o (dec_ready_o),
        .ex_valid_o  (ex_valid_o),
        .ex_pc_o     (ex_pc_o),
        .ex_inst_o   (ex_inst_o),
        .ex_ready_i  (ex_ready_i),
        .wb_valid_i  (wb_valid_i),
        .wb_rd_i     (wb_rd_i),
        .br_valid_i  (br_valid_i),
        .sb_o        (sb_o),
        .inflight_o  (inflight_o),
        .stall_cnt_o (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'h001, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [63:0] pc, input logic [31:0] inst, input bit will_issue);
        exp_t e;
        dec_valid_i = 1'b1;
        dec_pc_i    = pc;
        dec_inst_i  = inst;
        if (will_issue) begin
            e.pc   = pc;
            e.inst = inst;
            exp_q.push_back(e);
        end
        #1;
    endtask

    task automatic wb(input logic [4:0] r);
        wb_valid_i = 1'b1;
        wb_rd_i    = r;
        tick();
        wb_valid_i = 1'b0;
    endtask

    // Monitor: every handshake to execute must match the next expected inst in order.
    always @(negedge clk) begin
        if (reset && ex_valid_o && ex_ready_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL issue_unexpected: got pc %0h expected none", ex_pc_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("issue_pc", ex_pc_o, mon_e.pc);
                check("issue_inst", 64'(ex_inst_o), 64'(mon_e.inst));
            end
        end
    end

    initial begin
        reset = 1'b0; dec_valid_i = 1'b0; dec_pc_i = '0; dec_inst_i = '0;
        ex_ready_i = 1'b1; wb_valid_i = 1'b0; wb_rd_i = '0; br_valid_i = 1'b0;
        #12;
        check("rst_dec_ready", 64'(dec_ready_o), 1);
        check("rst_ex_valid", 64'(ex_valid_o), 0);
        check("rst_sb", 64'(sb_o), 0);
        check("rst_inflight", 64'(inflight_o), 0);
        check("rst_stall", 64'(stall_cnt_o), 0);
        tick();
        reset = 1'b1;
        tick();

        // RAW: dependent add waits for wb of x1, then issues in the wb cycle
        offer(64'h100, r_type(1, 2, 3), 1);
        check("t1_ready1", 64'(dec_ready_o), 1);
        tick();
        offer(64'h104, r_type(4, 1, 5), 1);
        check("t1_ready2", 64'(dec_ready_o), 1);
        tick();
        dec_valid_i = 1'b0;
        #1;
        check("t1_raw_hold", 64'(ex_valid_o), 0);
        check("t1_not_ready", 64'(dec_ready_o), 0);
        check("t1_sb", 64'(sb_o), 32'h2);
        check("t1_inflight", 64'(inflight_o), 1);
        tick();
        tick();
        check("t1_stall", 64'(stall_cnt_o), 2);
        wb_valid_i = 1'b1; wb_rd_i = 5'd1;
        #1;
        check("t1_wake", 64'(ex_valid_o), 1);
        tick();
        wb_valid_i = 1'b0;
        #1;
        check("t1_sb_after", 64'(sb_o), 32'h10);
        check("t1_inflight_after", 64'(inflight_o), 1);
        wb(5'd4);
        check("t1_drain", 64'(sb_o), 0);

        // In-flight cap: 4 issue, 5th waits for a writeback
        for (int k = 0; k < 5; k++) begin
            offer(64'(32'h200 + 4 * k), i_type(5'(10 + k), 5'd0), 1);
            check("t2_ready", 64'(dec_ready_o), 1);
            tick();
        end
        dec_valid_i = 1'b0;
        #1;
        check("t2_cap_hold", 64'(ex_valid_o), 0);
        check("t2_inflight_max", 64'(inflight_o), 4);
        check("t2_sb", 64'(sb_o), 32'h3C00);
        tick();
        tick();
        check("t2_still_hold", 64'(ex_valid_o), 0);
        wb_valid_i = 1'b1; wb_rd_i = 5'd10;
        #1;
        check("t2_wake", 64'(ex_valid_o), 1);
        tick();
        wb_valid_i = 1'b0;
        #1;
        check("t2_inflight_after", 64'(inflight_o), 4);
        check("t2_sb_after", 64'(sb_o), 32'h7800);
        for (int r = 11; r < 15; r++) wb(5'(r));
        check("t2_drain_inflight", 64'(inflight_o), 0);
        check("t2_drain_sb", 64'(sb_o), 0);

        // Branch redirect drops held entry and the next decode offers
        offer(64'h300, i_type(5'd20, 5'd0), 1);
        tick();
        dec_valid_i = 1'b0;
        tick();
        ex_ready_i = 1'b0;
        offer(64'h304, i_type(5'd21, 5'd0), 0);
        tick();
        check("t3_held_valid", 64'(ex_valid_o), 1);
        br_valid_i = 1'b1;
        offer(64'h308, i_type(5'd22, 5'd0), 0);
        check("t3_br_ex_valid", 64'(ex_valid_o), 0);
        check("t3_br_ready", 64'(dec_ready_o), 0);
        tick();
        br_valid_i = 1'b0; ex_ready_i = 1'b1;
        #1;
        check("t3_flush_ready", 64'(dec_ready_o), 0);
        check("t3_flush_ex_valid", 64'(ex_valid_o), 0);
        check("t3_flush_sb", 64'(sb_o), 32'h0010_0000);
        tick();
        check("t3_post_flush_ready", 64'(dec_ready_o), 1);
        offer(64'h30C, i_type(5'd22, 5'd0), 1);
        tick();
        dec_valid_i = 1'b0;
        tick();
        check("t3_sb", 64'(sb_o), 32'h0050_0000);
        check("t3_inflight", 64'(inflight_o), 2);
        wb(5'd20);
        wb(5'd22);
        check("t3_drain", 64'(inflight_o), 0);

        // WAW on x7 woken by same-cycle wb; set wins over clear
        offer(64'h400, i_type(5'd7, 5'd0), 1);
        tick();
        offer(64'h404, i_type(5'd7, 5'd0), 1);
        tick();
        dec_valid_i = 1'b0;
        #1;
        check("t4_waw_hold", 64'(ex_valid_o), 0);
        wb_valid_i = 1'b1; wb_rd_i = 5'd7;
        #1;
        check("t4_wake", 64'(ex_valid_o), 1);
        tick();
        wb_valid_i = 1'b0;
        #1;
        check("t4_set_wins", 64'(sb_o), 32'h80);
        check("t4_inflight", 64'(inflight_o), 1);
        wb(5'd7);
        check("t4_drain", 64'(sb_o), 0);

        // x0 handling and stray writebacks
        wb(5'd5);
        check("t5_stray_inflight", 64'(inflight_o), 0);
        check("t5_stray_sb", 64'(sb_o), 0);
        offer(64'h500, {20'h12345, 5'd0, 7'b0110111}, 1);
        tick();
        offer(64'h504, r_type(5'd3, 5'd0, 5'd0), 1);
        tick();
        dec_valid_i = 1'b0;
        tick();
        check("t5_sb", 64'(sb_o), 32'h8);
        check("t5_inflight", 64'(inflight_o), 2);
        check("t5_no_stall", 64'(stall_cnt_o), 4);
        wb(5'd0);
        check("t5_wb0_sb", 64'(sb_o), 32'h8);
        check("t5_wb0_inflight", 64'(inflight_o), 2);

        // Asynchronous reset mid-stall
        offer(64'h600, r_type(5'd9, 5'd3, 5'd3), 0);
        tick();
        dec_valid_i = 1'b0;
        tick();
        check("t6_stall_hold", 64'(ex_valid_o), 0);
        check("t6_stall_cnt", 64'(stall_cnt_o), 5);
        reset = 1'b0;
        #1;
        check("t6_dec_ready", 64'(dec_ready_o), 1);
        check("t6_ex_valid", 64'(ex_valid_o), 0);
        check("t6_sb", 64'(sb_o), 0);
        check("t6_inflight", 64'(inflight_o), 0);
        check("t6_stall", 64'(stall_cnt_o), 0);
        tick();
        reset = 1'b1;
        tick();
        check("exp_q_empty", 64'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
